// File: rtl/rle_stream_writer_if.sv
// rle_stream_writer_if: token stream and RAM bus bundles for the RLE stream writer
interface rle_tok_if #(parameter int LEN_W = 7);
  logic tok_valid, tok_ready, tok_bit, tok_last;
  logic [LEN_W-1:0] tok_len;
  modport master (output tok_valid, tok_bit, tok_len, tok_last, input tok_ready);
  modport slave (input tok_valid, tok_bit, tok_len, tok_last, output tok_ready);
endinterface

interface rle_ram_if #(parameter int ADDR_W = 16, WORD_W = 8);
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata, ram_rdata;
  logic ram_rd, ram_wr;
  modport master (output ram_addr, ram_wdata, ram_rd, ram_wr, input ram_rdata);
  modport slave (input ram_addr, ram_wdata, ram_rd, ram_wr, output ram_rdata);
endinterface

// File: rtl/rle_stream_writer.sv
// rle_stream_writer: expands run-length tokens into an MSB-first bit stream in RAM, preserving bits outside the written span
module rle_stream_writer #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 16,
  parameter int LEN_W = 7,
  parameter int BIT_W = 3
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_byte,
  input  logic [BIT_W-1:0]  start_bit,
  input  logic [ADDR_W-1:0] end_addr,
  rle_tok_if.slave          tok,
  rle_ram_if.master         ram,
  output logic [ADDR_W-1:0] new_byte,
  output logic [BIT_W-1:0]  new_bit,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  typedef enum logic [3:0] {IDLE, PRE_RD, PRE_WAIT, FILL, WRITE, FLUSH_RD, FLUSH_WAIT, FLUSH_WR, FIN} state_t;
  localparam int CW = (LEN_W > BIT_W ? LEN_W : BIT_W) + 1;
  localparam logic [BIT_W-1:0] TOP = BIT_W'(WORD_W - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] word, word_n, last, last_n;
  logic [BIT_W-1:0] cur_bit, cur_bit_n;
  logic [WORD_W-1:0] acc, acc_n, low_mask, run_mask;
  logic [LEN_W-1:0] run, run_n;
  logic run_val, run_val_n, flush, flush_n, ovf_n, hs;
  logic [CW-1:0] room, take, low;
  // next-state, run placement and read-merge datapath
  always_comb begin
    state_n = state;
    word_n = word;
    last_n = last;
    cur_bit_n = cur_bit;
    acc_n = acc;
    run_n = run;
    run_val_n = run_val;
    flush_n = flush;
    ovf_n = overflow;
    hs = tok.tok_valid && tok.tok_ready;
    room = CW'(cur_bit) + CW'(1);
    take = CW'(run) < room ? CW'(run) : room;
    low = room - take;
    for (int i = 0; i < WORD_W; i++) begin
      low_mask[i] = i < int'(room);
      run_mask[i] = (i < int'(room)) && (i >= int'(low));
    end
    case (state)
      IDLE: if (start) begin
        word_n = start_byte;
        cur_bit_n = start_bit;
        last_n = end_addr;
        ovf_n = 1'b0;
        flush_n = 1'b0;
        run_n = '0;
        state_n = start_bit == TOP ? FILL : PRE_RD;
      end
      PRE_RD: state_n = PRE_WAIT;
      PRE_WAIT: begin
        acc_n = ram.ram_rdata;
        state_n = FILL;
      end
      FILL: if (run != '0) begin
        acc_n = run_val ? acc | run_mask : acc & ~run_mask;
        run_n = run - LEN_W'(take);
        cur_bit_n = low == '0 ? TOP : BIT_W'(low - CW'(1));
        state_n = low == '0 ? WRITE : FILL;
      end else begin
        if (hs) begin
          run_n = tok.tok_len;
          run_val_n = tok.tok_bit;
          flush_n = tok.tok_last;
        end
        if (flush || (hs && tok.tok_last && tok.tok_len == '0))
          state_n = cur_bit == TOP ? FIN : FLUSH_RD;
      end
      WRITE: begin
        word_n = word + ADDR_W'(1);
        state_n = FILL;
      end
      FLUSH_RD: state_n = FLUSH_WAIT;
      FLUSH_WAIT: begin
        acc_n = (acc & ~low_mask) | (ram.ram_rdata & low_mask);
        state_n = FLUSH_WR;
      end
      FLUSH_WR: state_n = FIN;
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if ((state_n == WRITE || state_n == FLUSH_WR) && word_n > last) ovf_n = 1'b1;
  end
  // state/datapath registers; every output is decoded from the next state so it is registered
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
      word <= '0;
      last <= '0;
      cur_bit <= TOP;
      acc <= '0;
      run <= '0;
      run_val <= 1'b0;
      flush <= 1'b0;
      overflow <= 1'b0;
      tok.tok_ready <= 1'b0;
      ram.ram_rd <= 1'b0;
      ram.ram_wr <= 1'b0;
      ram.ram_addr <= '0;
      ram.ram_wdata <= '0;
      new_byte <= '0;
      new_bit <= TOP;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      word <= word_n;
      last <= last_n;
      cur_bit <= cur_bit_n;
      acc <= acc_n;
      run <= run_n;
      run_val <= run_val_n;
      flush <= flush_n;
      overflow <= ovf_n;
      tok.tok_ready <= state_n == FILL && run_n == '0 && !flush_n;
      ram.ram_rd <= state_n == PRE_RD || state_n == FLUSH_RD;
      ram.ram_wr <= (state_n == WRITE || state_n == FLUSH_WR) && word_n <= last_n;
      ram.ram_addr <= word_n;
      ram.ram_wdata <= acc_n;
      busy <= state_n != IDLE && state_n != FIN;
      done <= state_n == FIN;
      if (state_n == FIN) begin
        new_byte <= word_n;
        new_bit <= cur_bit_n;
      end
    end
  end
endmodule

// File: tb/tb_rle_stream_writer.sv
// tb_rle_stream_writer: directed scenarios against a behavioural byte RAM with hand-computed results
module tb_rle_stream_writer;
  logic clk = 1'b0, RST = 1'b1, start = 1'b0;
  logic [15:0] start_byte = '0, end_addr = '0, new_byte;
  logic [2:0] start_bit = '0, new_bit;
  logic busy, done, overflow;
  logic poke = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [7:0] poke_data = '0;
  logic [7:0] mem [0:65535];
  int rd_cnt = 0, wr_cnt = 0, checks = 0, errors = 0;

  rle_tok_if #(.LEN_W(7)) tok();
  rle_ram_if #(.ADDR_W(16), .WORD_W(8)) ram();

  rle_stream_writer #(.WORD_W(8), .ADDR_W(16), .LEN_W(7), .BIT_W(3)) dut (
    .clk(clk), .RST(RST), .start(start), .start_byte(start_byte), .start_bit(start_bit),
    .end_addr(end_addr), .tok(tok), .ram(ram), .new_byte(new_byte), .new_bit(new_bit),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // byte RAM with one-cycle read latency plus a preload port for the bench
  always @(posedge clk) begin
    if (poke) mem[poke_addr] <= poke_data;
    if (ram.ram_wr) begin
      mem[ram.ram_addr] <= ram.ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (ram.ram_rd) begin
      ram.ram_rdata <= mem[ram.ram_addr];
      rd_cnt <= rd_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    poke = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke = 1'b0;
  endtask

  task automatic begin_job(input logic [15:0] a, input logic [2:0] b, input logic [15:0] e);
    @(negedge clk);
    start_byte = a; start_bit = b; end_addr = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic v, input logic [6:0] len, input logic lst, output int waits);
    tok.tok_bit = v; tok.tok_len = len; tok.tok_last = lst; tok.tok_valid = 1'b1;
    waits = 0;
    while (!tok.tok_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (!tok.tok_ready) begin
      errors++;
      $display("FAIL tok_accept got ready=0 after %0d cycles want ready=1", waits);
    end
    @(negedge clk);
    tok.tok_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done got %b want 1", nm, done);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s_done_pulse got done,busy=%b want 00", nm, {done, busy});
    end
  endtask

  task automatic test_reset;
    tok.tok_valid = 1'b0; tok.tok_bit = 1'b0; tok.tok_len = '0; tok.tok_last = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, overflow, ram.ram_rd, ram.ram_wr, tok.tok_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000", {busy, done, overflow, ram.ram_rd, ram.ram_wr, tok.tok_ready});
    end
    checks++;
    if ({new_byte, new_bit} !== {16'h0000, 3'd7}) begin
      errors++;
      $display("FAIL reset_cursor got %h/%0d want 0000/7", new_byte, new_bit);
    end
    RST = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_aligned(input logic [15:0] base, input string nm);
    int r0, w0, w;
    preload(base + 16'd1, 8'h55);
    r0 = rd_cnt; w0 = wr_cnt;
    begin_job(base, 3'd7, 16'hFFFF);
    send(1'b1, 7'd8, 1'b0, w);
    send(1'b0, 7'd8, 1'b1, w);
    wait_done(nm);
    checks++;
    if ({mem[base], mem[base + 16'd1]} !== 16'hFF00) begin
      errors++;
      $display("FAIL %s_data got %h%h want FF00", nm, mem[base], mem[base + 16'd1]);
    end
    checks++;
    if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 2) begin
      errors++;
      $display("FAIL %s_accesses got rd=%0d wr=%0d want rd=0 wr=2", nm, rd_cnt - r0, wr_cnt - w0);
    end
    checks++;
    if ({new_byte, new_bit} !== {base + 16'd2, 3'd7}) begin
      errors++;
      $display("FAIL %s_cursor got %h/%0d want %h/7", nm, new_byte, new_bit, base + 16'd2);
    end
  endtask

  task automatic test_partial;
    int r0, w0, w;
    preload(16'h0020, 8'hA5);
    r0 = rd_cnt; w0 = wr_cnt;
    begin_job(16'h0020, 3'd3, 16'hFFFF);
    send(1'b1, 7'd2, 1'b1, w);
    wait_done("partial");
    checks++;
    if (mem[16'h0020] !== 8'hAD) begin
      errors++;
      $display("FAIL partial_data got %h want AD", mem[16'h0020]);
    end
    checks++;
    if (rd_cnt - r0 !== 2 || wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL partial_accesses got rd=%0d wr=%0d want rd=2 wr=1", rd_cnt - r0, wr_cnt - w0);
    end
    checks++;
    if ({new_byte, new_bit} !== {16'h0020, 3'd1}) begin
      errors++;
      $display("FAIL partial_cursor got %h/%0d want 0020/1", new_byte, new_bit);
    end
  endtask

  task automatic test_long_run;
    int r0, w0, w, bad;
    preload(16'h0030, 8'h00);
    preload(16'h0040, 8'h5A);
    r0 = rd_cnt; w0 = wr_cnt;
    begin_job(16'h0030, 3'd5, 16'hFFFF);
    send(1'b1, 7'd127, 1'b1, w);
    wait_done("long");
    bad = 0;
    for (int a = 16'h31; a <= 16'h3F; a++) if (mem[a] !== 8'hFF) bad++;
    checks++;
    if (mem[16'h0030] !== 8'h3F || bad !== 0) begin
      errors++;
      $display("FAIL long_body got head=%h bad_words=%0d want head=3F bad_words=0", mem[16'h0030], bad);
    end
    checks++;
    if (mem[16'h0040] !== 8'hDA) begin
      errors++;
      $display("FAIL long_tail got %h want DA", mem[16'h0040]);
    end
    checks++;
    if (rd_cnt - r0 !== 2 || wr_cnt - w0 !== 17) begin
      errors++;
      $display("FAIL long_accesses got rd=%0d wr=%0d want rd=2 wr=17", rd_cnt - r0, wr_cnt - w0);
    end
    checks++;
    if ({new_byte, new_bit} !== {16'h0040, 3'd6}) begin
      errors++;
      $display("FAIL long_cursor got %h/%0d want 0040/6", new_byte, new_bit);
    end
  endtask

  task automatic test_backpressure;
    int w0, w;
    preload(16'h0054, 8'h99);
    w0 = wr_cnt;
    begin_job(16'h0050, 3'd7, 16'hFFFF);
    send(1'b1, 7'd20, 1'b0, w);
    checks++;
    if (tok.tok_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_drop got %b want 0", tok.tok_ready);
    end
    send(1'b0, 7'd0, 1'b0, w);
    checks++;
    if (w !== 5) begin
      errors++;
      $display("FAIL bp_stall_cycles got %0d want 5", w);
    end
    send(1'b0, 7'd12, 1'b1, w);
    wait_done("bp");
    checks++;
    if ({mem[16'h0050], mem[16'h0051], mem[16'h0052], mem[16'h0053], mem[16'h0054]} !== 40'hFFFF_F000_99) begin
      errors++;
      $display("FAIL bp_data got %h %h %h %h %h want FF FF F0 00 99", mem[16'h0050], mem[16'h0051], mem[16'h0052], mem[16'h0053], mem[16'h0054]);
    end
    checks++;
    if (wr_cnt - w0 !== 4 || {new_byte, new_bit} !== {16'h0054, 3'd7}) begin
      errors++;
      $display("FAIL bp_writes_cursor got wr=%0d %h/%0d want wr=4 0054/7", wr_cnt - w0, new_byte, new_bit);
    end
  endtask

  task automatic test_overflow;
    int w0, w;
    preload(16'h0040, 8'hEE);
    preload(16'h0041, 8'h77);
    w0 = wr_cnt;
    begin_job(16'h0040, 3'd7, 16'h0040);
    send(1'b0, 7'd16, 1'b1, w);
    wait_done("ovf");
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got %b want 1", overflow);
    end
    checks++;
    if ({mem[16'h0040], mem[16'h0041]} !== 16'h0077 || wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL ovf_data got %h %h wr=%0d want 00 77 wr=1", mem[16'h0040], mem[16'h0041], wr_cnt - w0);
    end
    checks++;
    if (new_byte !== 16'h0042) begin
      errors++;
      $display("FAIL ovf_cursor got %h want 0042", new_byte);
    end
    w0 = wr_cnt;
    begin_job(16'h0070, 3'd7, 16'hFFFF);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b want 0", overflow);
    end
    send(1'b1, 7'd0, 1'b1, w);
    wait_done("empty");
    checks++;
    if (wr_cnt - w0 !== 0 || {new_byte, new_bit} !== {16'h0070, 3'd7}) begin
      errors++;
      $display("FAIL empty_job got wr=%0d %h/%0d want wr=0 0070/7", wr_cnt - w0, new_byte, new_bit);
    end
  endtask

  task automatic test_reset_mid_job;
    int w, n;
    begin_job(16'h0060, 3'd7, 16'hFFFF);
    send(1'b1, 7'd8, 1'b0, w);
    n = 0;
    while (!ram.ram_wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ram.ram_wr !== 1'b1) begin
      errors++;
      $display("FAIL rst_reach_write got %b want 1", ram.ram_wr);
    end
    RST = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram.ram_wr, busy, tok.tok_ready, new_bit} !== {3'b000, 3'd7}) begin
      errors++;
      $display("FAIL rst_abort got wr,busy,ready=%b bit=%0d want 000/7", {ram.ram_wr, busy, tok.tok_ready}, new_bit);
    end
    RST = 1'b0;
    @(negedge clk);
    test_aligned(16'h0068, "after_rst");
  endtask

  initial begin
    test_reset;
    test_aligned(16'h0010, "aligned");
    test_partial;
    test_long_run;
    test_backpressure;
    test_overflow;
    test_reset_mid_job;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
